// File: rtl/video_capture_unit_if.sv
// video_capture_unit_if: VGA-timed pixel stream toward the capture unit and its video-memory write port.
interface video_capture_unit_if;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic hsync;
  logic vsync;
  logic wr_en;
  logic [3:0] wr_we;
  logic [14:0] wr_addr;
  logic [31:0] wr_data;
  modport master (output red, green, blue, hsync, vsync, input wr_en, wr_we, wr_addr, wr_data);
  modport slave (input red, green, blue, hsync, vsync, output wr_en, wr_we, wr_addr, wr_data);
endinterface

// File: rtl/video_capture_unit.sv
// video_capture_unit: recovers VGA timing from sync edges and writes a 2x-decimated 128x128 window to video memory.
module video_capture_unit #(
  parameter logic H_SYNC_ACTIVE = 1'b0,
  parameter logic V_SYNC_ACTIVE = 1'b0,
  parameter int H_FRAME_WIDTH = 640,
  parameter int H_BACK_PORCH = 48,
  parameter int H_TOTAL_WIDTH = 800,
  parameter int V_FRAME_WIDTH = 480,
  parameter int V_BACK_PORCH = 33
) (
  input logic clk_a,
  input logic rst,
  video_capture_unit_if.slave vid,
  input logic arm,
  input logic continuous,
  input logic abort,
  input logic [14:0] base,
  input logic err_clr,
  output logic busy,
  output logic frame_done,
  output logic [15:0] frame_count,
  output logic line_error,
  output logic frame_error
);
  localparam logic [15:0] H_START = 16'(H_BACK_PORCH);
  localparam logic [15:0] H_STOP = 16'(H_BACK_PORCH + H_FRAME_WIDTH);
  localparam logic [15:0] H_LAST = 16'(H_TOTAL_WIDTH - 1);
  localparam logic [15:0] V_START = 16'(V_BACK_PORCH);
  localparam logic [15:0] V_STOP = 16'(V_BACK_PORCH + V_FRAME_WIDTH);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;
  state_t state, state_n;
  logic [23:0] r_rgb;
  logic r_hsync, r_vsync, p_hsync, p_vsync, hs_seen;
  logic [15:0] h_cnt, line_cnt, h_now, line_now, x, y;
  logic [14:0] base_q;
  logic hs_end, vs_end, vs_start, frame_end, frame_bad, line_bad, wr_go;
  assign hs_end = p_hsync == H_SYNC_ACTIVE && r_hsync != H_SYNC_ACTIVE;
  assign vs_end = p_vsync == V_SYNC_ACTIVE && r_vsync != V_SYNC_ACTIVE;
  assign vs_start = p_vsync != V_SYNC_ACTIVE && r_vsync == V_SYNC_ACTIVE;
  // Position of the pixel currently held in r_rgb; the registers keep the same value for the next cycle.
  assign h_now = hs_end ? 16'd0 : &h_cnt ? h_cnt : h_cnt + 16'd1;
  assign line_now = vs_end ? 16'd0 : hs_end && !(&line_cnt) ? line_cnt + 16'd1 : line_cnt;
  assign x = h_now - H_START;
  assign y = line_now - V_START;
  assign frame_end = state == CAPTURE && !abort && line_now == V_STOP;
  assign frame_bad = state == CAPTURE && !frame_end && vs_start;
  assign line_bad = hs_end && hs_seen && h_cnt != H_LAST;
  assign wr_go = state == CAPTURE && !abort && h_now >= H_START && h_now < H_STOP &&
    line_now >= V_START && line_now < V_STOP && x[15:8] == 8'd0 && y[15:8] == 8'd0 && !x[0] && !y[0];
  assign busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE ? (arm ? WAIT_FRAME : IDLE) :
              state == WAIT_FRAME ? (vs_end ? CAPTURE : WAIT_FRAME) :
              frame_end ? (continuous ? WAIT_FRAME : IDLE) :
              vs_start ? WAIT_FRAME : CAPTURE;
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk_a or posedge rst)
    if (rst) begin
      state <= IDLE;
      r_rgb <= '0;
      r_hsync <= !H_SYNC_ACTIVE;
      r_vsync <= !V_SYNC_ACTIVE;
      p_hsync <= !H_SYNC_ACTIVE;
      p_vsync <= !V_SYNC_ACTIVE;
      hs_seen <= 1'b0;
      h_cnt <= '0;
      line_cnt <= '0;
      base_q <= '0;
      vid.wr_en <= 1'b0;
      vid.wr_we <= '0;
      vid.wr_addr <= '0;
      vid.wr_data <= '0;
      frame_done <= 1'b0;
      frame_count <= '0;
      line_error <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state <= state_n;
      r_rgb <= {vid.red, vid.green, vid.blue};
      r_hsync <= vid.hsync;
      r_vsync <= vid.vsync;
      p_hsync <= r_hsync;
      p_vsync <= r_vsync;
      hs_seen <= hs_seen | hs_end;
      h_cnt <= h_now;
      line_cnt <= line_now;
      if (state == WAIT_FRAME && vs_end) base_q <= base;
      vid.wr_en <= wr_go;
      vid.wr_we <= {4{wr_go}};
      if (wr_go) begin
        vid.wr_addr <= {1'b0, y[7:1], x[7:1]} + base_q;
        vid.wr_data <= {8'd0, r_rgb};
      end
      frame_done <= frame_end;
      frame_count <= frame_count + 16'(frame_end);
      line_error <= line_bad | (line_error & !err_clr);
      frame_error <= frame_bad | (frame_error & !err_clr);
    end
endmodule

// File: tb/tb_video_capture_unit.sv
// tb_video_capture_unit: directed VGA frames into the capture unit with a write scoreboard.
module tb_video_capture_unit;
  localparam int HS = 4, HB = 8, HF = 260, HT = 280, VB = 2, VF = 6, VT = 10;
  localparam int PIX0 = HS + HB;
  typedef struct {
    logic [14:0] addr;
    logic [31:0] data;
    int cyc;
  } wr_t;
  logic clk_a = 1'b0, rst = 1'b1, arm = 1'b0, continuous = 1'b0, abort = 1'b0, err_clr = 1'b0;
  logic [14:0] base = '0;
  logic busy, frame_done, line_error, frame_error;
  logic [15:0] frame_count;
  wr_t sb[$];
  wr_t e;
  int total = 0, passed = 0, cyc = 0, wr_cnt = 0, fd_cnt = 0, fd_last = 0, fd_prev = 0;
  int ev_line = -1, ev_c = -1, ev_kind = 0, short_line = -1;
  bit exp_cap = 1'b0;
  video_capture_unit_if vif();
  video_capture_unit #(
    .H_FRAME_WIDTH(HF), .H_BACK_PORCH(HB), .H_TOTAL_WIDTH(HT),
    .V_FRAME_WIDTH(VF), .V_BACK_PORCH(VB)
  ) dut (
    .clk_a(clk_a), .rst(rst), .vid(vif), .arm(arm), .continuous(continuous), .abort(abort),
    .base(base), .err_clr(err_clr), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .line_error(line_error), .frame_error(frame_error)
  );
  always #5 clk_a = ~clk_a;
  always @(posedge clk_a) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(negedge clk_a) begin
    if (frame_done) begin
      fd_cnt++;
      fd_prev = fd_last;
      fd_last = cyc;
    end
    if (vif.wr_en) begin
      wr_cnt++;
      chk("wr_we", 64'(vif.wr_we), 64'(4'hF));
      chk("write_pending", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 64'(vif.wr_addr), 64'(e.addr));
        chk("wr_data", 64'(vif.wr_data), 64'(e.data));
        chk("wr_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end
  // Line 0 carries vsync; pulses (1 arm, 2 abort+arm, 3 rst, 4 err_clr) fire at (ev_line, ev_c).
  task automatic video_frame(input int nlines);
    int len, x, y;
    bit act;
    for (int ln = 0; ln < nlines; ln++) begin
      len = ln == short_line ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        x = c - PIX0;
        y = ln - VB;
        act = ln >= VB && ln < VB + VF && x >= 0 && x < HF;
        @(negedge clk_a);
        arm = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
        err_clr = 1'b0;
        if (ln == ev_line && c == ev_c - 1 && ev_kind inside {2, 3}) exp_cap = 1'b0;
        if (ln == ev_line && c == ev_c) begin
          arm = ev_kind inside {1, 2};
          abort = ev_kind == 2;
          rst = ev_kind == 3;
          err_clr = ev_kind == 4;
          ev_line = -1;
        end
        vif.hsync = c >= HS;
        vif.vsync = ln != 0;
        {vif.red, vif.green, vif.blue} = act ? {8'(x), 8'(y), 8'h5A} : 24'hEEEEEE;
        if (exp_cap && act && x < 256 && y < 256 && x % 2 == 0 && y % 2 == 0)
          sb.push_back('{15'((y / 2) * 128 + x / 2 + int'(base)), {8'd0, 8'(x), 8'(y), 8'h5A}, cyc + 2});
      end
    end
  endtask
  task automatic frame(input int nlines, input int kind, input int eline, input int ec, input bit cap);
    ev_kind = kind;
    ev_line = eline;
    ev_c = ec;
    exp_cap = cap;
    wr_cnt = 0;
    video_frame(nlines);
  endtask
  initial begin
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    {vif.red, vif.green, vif.blue} = '0;
    repeat (3) @(negedge clk_a);
    chk("rst_wr_en", 64'(vif.wr_en), 64'(0));
    chk("rst_wr_we", 64'(vif.wr_we), 64'(0));
    chk("rst_wr_addr", 64'(vif.wr_addr), 64'(0));
    chk("rst_wr_data", 64'(vif.wr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    chk("rst_line_error", 64'(line_error), 64'(0));
    chk("rst_frame_error", 64'(frame_error), 64'(0));
    rst = 1'b0;
    frame(VT, 1, 0, 0, 1'b1);
    chk("t1_writes", 64'(wr_cnt), 64'(384));
    chk("t1_sb_empty", 64'(sb.size()), 64'(0));
    chk("t1_frame_done", 64'(fd_cnt), 64'(1));
    chk("t1_frame_count", 64'(frame_count), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_line_error", 64'(line_error), 64'(0));
    chk("t1_frame_error", 64'(frame_error), 64'(0));
    base = 15'h7FF0;
    frame(VT, 1, 0, 0, 1'b1);
    chk("t2_writes", 64'(wr_cnt), 64'(384));
    chk("t2_sb_empty", 64'(sb.size()), 64'(0));
    chk("t2_frame_count", 64'(frame_count), 64'(2));
    base = '0;
    continuous = 1'b1;
    frame(VT, 1, 0, 0, 1'b1);
    chk("t3_busy1", 64'(busy), 64'(1));
    frame(VT, 0, -1, -1, 1'b1);
    chk("t3_busy2", 64'(busy), 64'(1));
    frame(VT, 0, -1, -1, 1'b1);
    chk("t3_busy3", 64'(busy), 64'(1));
    chk("t3_writes", 64'(wr_cnt), 64'(384));
    chk("t3_frame_count", 64'(frame_count), 64'(5));
    chk("t3_frame_done", 64'(fd_cnt), 64'(5));
    chk("t3_spacing", 64'(fd_last - fd_prev), 64'(HT * VT));
    short_line = 3;
    frame(VT, 0, -1, -1, 1'b1);
    short_line = -1;
    chk("t4_line_error", 64'(line_error), 64'(1));
    chk("t4_frame_count", 64'(frame_count), 64'(6));
    frame(5, 4, 0, 0, 1'b1);
    chk("t4_err_clr", 64'(line_error), 64'(0));
    chk("t5_trunc_writes", 64'(wr_cnt), 64'(256));
    frame(VT, 0, -1, -1, 1'b1);
    chk("t5_frame_error", 64'(frame_error), 64'(1));
    chk("t5_frame_count", 64'(frame_count), 64'(7));
    chk("t5_frame_done", 64'(fd_cnt), 64'(7));
    chk("t5_writes", 64'(wr_cnt), 64'(384));
    continuous = 1'b0;
    frame(VT, 2, VB + 2, PIX0 + 9, 1'b1);
    chk("t6_writes", 64'(wr_cnt), 64'(132));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_frame_count", 64'(frame_count), 64'(7));
    chk("t6_frame_done", 64'(fd_cnt), 64'(7));
    frame(VT, 0, -1, -1, 1'b0);
    chk("t6_idle_writes", 64'(wr_cnt), 64'(0));
    chk("t6_idle_busy", 64'(busy), 64'(0));
    continuous = 1'b1;
    frame(VT, 1, 0, 0, 1'b1);
    chk("t7_frame_count", 64'(frame_count), 64'(8));
    frame(VT, 3, VB + 2, PIX0 + 9, 1'b1);
    chk("t7_writes", 64'(wr_cnt), 64'(132));
    chk("t7_rst_count", 64'(frame_count), 64'(0));
    chk("t7_rst_busy", 64'(busy), 64'(0));
    chk("t7_rst_frame_error", 64'(frame_error), 64'(0));
    frame(VT, 0, -1, -1, 1'b0);
    chk("t7_idle_writes", 64'(wr_cnt), 64'(0));
    chk("t7_line_error", 64'(line_error), 64'(0));
    chk("t7_busy", 64'(busy), 64'(0));
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
